// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding, line levels and parity helper for serial_frame_rx.
package serial_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, RESYNC} state_t;
  localparam logic IDLE_LVL = 1'b0;
  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL = 1'b0;
  function automatic logic parity(input logic [31:0] w, input logic odd);
    return ^w ^ odd;
  endfunction
endpackage

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed one-bit-per-clock serial receiver with valid/ready word output and error pulses.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_EN = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic par_bit, last, stop_ok, par_ok, good, load, perr, ferr;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = in == START_LVL ? DATA : IDLE;
      DATA:    next = !last ? DATA : PARITY_EN != 0 ? PAR : STOP;
      PAR:     next = STOP;
      STOP:    next = in == STOP_LVL ? IDLE : RESYNC;
      RESYNC:  next = in == IDLE_LVL ? IDLE : RESYNC;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    last = cnt == CW'(WIDTH - 1);
    busy = state != IDLE;
    stop_ok = state == STOP && in == STOP_LVL;
    ferr = state == STOP && in != STOP_LVL;
    par_ok = PARITY_EN == 0 || par_bit == parity(32'(shreg), PARITY_ODD != 0);
    good = stop_ok && par_ok;
    perr = stop_ok && !par_ok;
    load = good && (!valid || ready);
  end
  // Shift register is fully overwritten each frame, so it needs no clear between frames.
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      data <= '0;
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= state == IDLE ? '0 : state == DATA ? cnt + 1'b1 : cnt;
      if (state == DATA) shreg <= MSB_FIRST != 0 ? {shreg[WIDTH-2:0], in} : {in, shreg[WIDTH-1:1]};
      if (state == PAR) par_bit <= in;
      if (load) data <= shreg;
      valid <= load || (valid && !ready);
      parity_err <= perr;
      frame_err <= ferr;
      overrun <= good && valid && !ready;
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench with directed frames, random frames and a WIDTH=12 MSB-first instance.
module tb_serial_frame_rx;
  logic clk = 0, reset = 1, in = 0, ready = 0;
  logic [7:0] data;
  logic valid, parity_err, frame_err, overrun, busy;
  logic in1 = 0, rdy1 = 0;
  logic [11:0] d1;
  logic v1, pe1, fe1, ov1, b1;
  int total = 0, bad = 0;
  logic [7:0] wq[$];
  int eq[$];
  bit m_full = 0;
  int got, ekind;
  logic [7:0] ew;
  always #5 clk = ~clk;
  serial_frame_rx u0 (.clk(clk), .reset(reset), .in(in), .ready(ready), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy));
  serial_frame_rx #(.WIDTH(12), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u1 (.clk(clk), .reset(reset),
    .in(in1), .ready(rdy1), .data(d1), .valid(v1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // ev: 0 nothing completes, 1 good frame, 2 parity error, 3 stop-bit error
  task automatic tick(input logic b, input int rm, input int ev, input logic [7:0] w);
    logic r;
    r = rm == 2 ? 1'($urandom_range(1)) : rm[0];
    in = b;
    ready = r;
    if (!reset) begin
      if (ev == 1) begin
        if (!m_full || r) begin
          wq.push_back(w);
          m_full = 1;
        end else eq.push_back(3);
      end else begin
        if (ev == 2) eq.push_back(1);
        if (ev == 3) eq.push_back(2);
        if (r) m_full = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] w, input bit bp, input bit bs, input int rm, input int rl);
    tick(1, rm, 0, 0);
    for (int i = 0; i < 8; i++) tick(w[i], rm, 0, 0);
    tick(^w ^ bp, rm, 0, 0);
    tick(bs, rl, bs ? 3 : bp ? 2 : 1, w);
  endtask
  always @(negedge clk)
    if (!reset) begin
      if (valid && ready) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL word: got %0h want none", data);
        end else begin
          ew = wq.pop_front();
          if (data !== ew) begin
            bad++;
            $display("FAIL word: got %0h want %0h", data, ew);
          end
        end
      end
      if (parity_err || frame_err || overrun) begin
        got = parity_err ? 1 : frame_err ? 2 : 3;
        total++;
        ekind = eq.size() == 0 ? 0 : eq.pop_front();
        if (got != ekind) begin
          bad++;
          $display("FAIL pulse: got kind %0d want kind %0d", got, ekind);
        end
      end
    end
  initial begin
    logic [7:0] w;
    logic [11:0] sw;
    bit bp, bs;
    int n;
    repeat (3) tick(0, 0, 0, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {parity_err, frame_err, overrun}, 0);
    reset = 0;
    send(8'hA5, 0, 0, 0, 0);
    chk("a5_valid", valid, 1);
    chk("a5_data", data, 8'hA5);
    tick(0, 1, 0, 0);
    chk("a5_accept", valid, 0);
    send(8'hA5, 1, 0, 0, 0);
    chk("perr_pulse", parity_err, 1);
    chk("perr_valid", valid, 0);
    tick(0, 0, 0, 0);
    chk("perr_once", parity_err, 0);
    send(8'hA5, 0, 1, 0, 0);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_noperr", parity_err, 0);
    repeat (5) tick(1, 0, 0, 0);
    chk("resync_busy", busy, 1);
    chk("resync_valid", valid, 0);
    tick(0, 0, 0, 0);
    chk("resync_exit", busy, 0);
    send(8'h3C, 0, 0, 0, 0);
    chk("3c_data", data, 8'h3C);
    tick(0, 1, 0, 0);
    send(8'h11, 0, 0, 0, 0);
    send(8'h22, 0, 0, 0, 0);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_data", data, 8'h11);
    tick(0, 1, 0, 0);
    chk("ovr_drain", valid, 0);
    send(8'h11, 0, 0, 0, 0);
    send(8'h22, 0, 0, 0, 1);
    chk("swap_data", data, 8'h22);
    chk("swap_valid", valid, 1);
    chk("swap_noovr", overrun, 0);
    tick(0, 1, 0, 0);
    w = 8'h5A;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(w[i], 0, 0, 0);
    reset = 1;
    tick(0, 0, 0, 0);
    m_full = 0;
    chk("mid_rst_out", {data, valid, parity_err, frame_err, overrun, busy}, 0);
    reset = 0;
    send(8'h5A, 0, 0, 0, 0);
    chk("5a_data", data, 8'h5A);
    tick(0, 1, 0, 0);
    repeat (40) begin
      w = 8'($urandom);
      bp = $urandom_range(7) == 0;
      bs = $urandom_range(7) == 0;
      send(w, bp, bs, 2, 2);
      if (bs) begin
        repeat ($urandom_range(3)) tick(1, 2, 0, 0);
        tick(0, 2, 0, 0);
      end else repeat ($urandom_range(2)) tick(0, 2, 0, 0);
    end
    repeat (4) tick(0, 1, 0, 0);
    chk("words_left", wq.size(), 0);
    chk("pulses_left", eq.size(), 0);
    sw = 12'hABC;
    in1 = 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      n++;
      in1 = sw[11-i];
    end
    @(posedge clk);
    #1;
    n++;
    in1 = 0;
    while (!v1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w12_latency", n, 14);
    chk("w12_data", d1, 12'hABC);
    rdy1 = 1;
    @(posedge clk);
    #1;
    rdy1 = 0;
    chk("w12_accept", v1, 0);
    chk("w12_quiet", {pe1, fe1, ov1, b1}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Parametrised successor to the single-bit serial block.
- Receives framed words on a one-bit serial line, sampling one bit per clock: start bit, WIDTH data bits, optional parity bit, stop bit.
- Delivers each good word as a parallel word over a valid/ready handshake, and flags parity, framing and overrun errors.
- Sits between the serial input path and the parallel datapath that feeds the MLP layers.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- MSB_FIRST, 0, 0 = LSB of the word arrives first; 1 = MSB first.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity (data plus parity bit has an even count of ones); 1 = odd parity.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  serial line; idle = 0, start bit = 1, stop bit = 0; sampled every clk.
- data  output  WIDTH  received word, valid while valid = 1.
- valid  output  1  data holds an unconsumed word.
- ready  input  1  consumer accepts data on an edge where valid & ready.
- parity_err  output  1  one-cycle pulse; a frame failed parity and was dropped.
- frame_err  output  1  one-cycle pulse; the stop bit sampled as 1.
- overrun  output  1  one-cycle pulse; a good frame was dropped because the holding register was full.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 on the next edge with reset = 1.
  - State = IDLE, bit counter = 0, shift register = 0.
  - Reset mid-frame discards the partial frame without any error pulse.
- States:
  - IDLE: in = 1 goes to DATA and clears the counter; in = 0 stays in IDLE.
  - DATA: shift in one bit per cycle. After WIDTH bits, go to PAR if PARITY_EN = 1, else to STOP.
  - PAR: capture the parity bit, then go to STOP.
  - STOP: in = 0 completes the frame and goes to IDLE. in = 1 pulses frame_err, drops the frame and goes to RESYNC.
  - RESYNC: stay until in = 0, then go to IDLE. This prevents a stuck-high line from being read as back-to-back start bits.
- Bit order:
  - MSB_FIRST = 0: the first data bit lands in data[0].
  - MSB_FIRST = 1: the first data bit lands in data[WIDTH-1].
- Timing: if the start bit is sampled at edge k:
  - Data bits are sampled at edges k+1..k+WIDTH.
  - The parity bit, if enabled, is sampled at edge k+WIDTH+1.
  - The stop bit is sampled at edge s = k+WIDTH+1+PARITY_EN.
  - valid and the error pulses are visible after edge s; latency from start bit to valid is WIDTH+2+PARITY_EN cycles.
- Back-to-back frames: a start bit may be sampled at edge s+1, giving a minimum frame period of WIDTH+2+PARITY_EN cycles.
- Parity: the expected parity bit is XOR(data) ^ PARITY_ODD. On a mismatch with a good stop bit, pulse parity_err and do not load the frame.
- Holding register, on a completing good frame:
  - valid = 0, or valid & ready on the same edge: load data, valid = 1. A simultaneous accept and load keeps valid at 1 with the new word.
  - valid & !ready: keep the old word and pulse overrun.
- Stop-bit errors: when frame_err fires, parity is not checked and parity_err is not pulsed.
- Handshake: valid & ready with no new frame clears valid on that edge. data holds its value until the next load.
- Bit counter width: $clog2(WIDTH+1).

Decomposition:
- Package serial_pkg holds:
  - the state enum (IDLE, DATA, PAR, STOP, RESYNC);
  - the localparam line levels IDLE_LVL = 0, START_LVL = 1, STOP_LVL = 0;
  - a parity function taking a word and an odd flag.
- No sub-module: the FSM, shift register and holding register form one module of about 150–250 lines.

Test Plan (WIDTH = 8, LSB-first, even parity unless noted):
- Single frame 0xA5: in = 1 | 1,0,1,0,0,1,0,1 | 0 | 0, start bit at edge 10 -> valid = 1 and data = 0xA5 after edge 20; with ready = 1 at edge 21, valid = 0 after edge 21.
- Parity error: same frame with parity bit = 1 -> parity_err pulses for 1 cycle after edge 20; valid stays 0.
- Frame error, then a stuck-high line: stop bit = 1 with in held at 1 for 5 more cycles -> frame_err pulses once, FSM stays in RESYNC and no new frame starts; in = 0 then a frame of 0x3C -> data = 0x3C.
- Overrun: ready = 0, frames 0x11 then 0x22 back-to-back -> data stays 0x11 and overrun pulses after the second stop bit. Repeat with ready = 1 on the second completion edge -> data = 0x22 and valid stays 1.
- Parameter sweep: WIDTH = 12, MSB_FIRST = 1, PARITY_EN = 0, word 0xABC -> valid exactly 14 cycles after the start bit, data = 0xABC.
- Reset mid-frame: reset = 1 for one edge during data bit 4 -> all outputs 0 with no error pulse; the next full frame of 0x5A is received correctly.
